// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to sign/exponent/significand converter (value = F * 2^E).
// Normalises one left shift per cycle, then optionally rounds half-up and saturates.
module fp_convert_seq #(
  parameter int MAN_W    = 4,
  parameter int EXP_W    = 3,
  parameter int DIN_W    = 12,
  parameter int ROUND_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic [EXP_W-1:0] e,
  output logic [MAN_W-1:0] f,
  output logic             sat,
  output logic [2:0]       dbg_state
);

  generate
    if (DIN_W != MAN_W + (1 << EXP_W)) begin : g_bad_widths
      $fatal(1, "fp_convert_seq: DIN_W must equal MAN_W + 2**EXP_W");
    end
  endgenerate

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ABS   = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid is never withdrawn before it is taken, ready only in IDLE.

  logic [2:0]       state;
  logic [DIN_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic             sgn;
  logic             sat_path;

  logic [MAN_W:0]   ftmp;
  logic             rbit;
  logic [EXP_W-1:0] e_nxt;
  logic [MAN_W-1:0] f_nxt;
  logic             sat_nxt;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // Rounding carry out of the significand renormalises into the exponent,
  // which clamps to the maximum when it has no headroom left.
  always_comb begin
    rbit    = mag[DIN_W-2-MAN_W];
    ftmp    = {1'b0, mag[DIN_W-2 -: MAN_W]} + {{MAN_W{1'b0}}, ((ROUND_EN != 0) && rbit)};
    e_nxt   = cnt;
    f_nxt   = ftmp[MAN_W-1:0];
    sat_nxt = 1'b0;
    if (sat_path || (ftmp[MAN_W] && (cnt == {EXP_W{1'b1}}))) begin
      e_nxt   = {EXP_W{1'b1}};
      f_nxt   = {MAN_W{1'b1}};
      sat_nxt = 1'b1;
    end else if (ftmp[MAN_W]) begin
      e_nxt = cnt + 1'b1;
      f_nxt = {1'b1, {(MAN_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mag       <= '0;
      cnt       <= '0;
      sgn       <= 1'b0;
      sat_path  <= 1'b0;
      out_valid <= 1'b0;
      s         <= 1'b0;
      e         <= '0;
      f         <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn      <= din[DIN_W-1];
            mag      <= din;
            sat_path <= 1'b0;
            state    <= ABS;
          end
        end
        ABS: begin
          mag   <= sgn ? (~mag + 1'b1) : mag;
          cnt   <= {EXP_W{1'b1}};
          state <= NORM;
        end
        NORM: begin
          // Only the most negative input leaves the top bit set after negation.
          if (mag[DIN_W-1]) begin
            sat_path <= 1'b1;
            state    <= ROUND;
          end else if (mag[DIN_W-2] || (cnt == '0)) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            cnt <= cnt - 1'b1;
          end
        end
        ROUND: begin
          s         <= sgn;
          e         <= e_nxt;
          f         <= f_nxt;
          sat       <= sat_nxt;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
// Directed bench for fp_convert_seq: a rounding and a truncating instance share
// one input stream; results are checked against hand-computed vectors.
module tb_fp_convert_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] din;

  logic        in_ready, out_valid, s, sat;
  logic [2:0]  e;
  logic [3:0]  f;
  logic [2:0]  dbg_state;

  logic        in_ready_t, out_valid_t, s_t, sat_t;
  logic [2:0]  e_t;
  logic [3:0]  f_t;
  logic [2:0]  dbg_state_t;

  int checks = 0;
  int errors = 0;

  // Expected {round result, trunc result}, each packed as {s, e, f, sat}.
  logic [17:0] exp_q[$];

  fp_convert_seq #(.MAN_W(4), .EXP_W(3), .DIN_W(12), .ROUND_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .e(e), .f(f), .sat(sat),
    .dbg_state(dbg_state)
  );

  fp_convert_seq #(.MAN_W(4), .EXP_W(3), .DIN_W(12), .ROUND_EN(0)) u_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .din(din),
    .out_valid(out_valid_t), .out_ready(out_ready), .s(s_t), .e(e_t), .f(f_t), .sat(sat_t),
    .dbg_state(dbg_state_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after the take.
  task automatic run_vec(input logic [11:0] d, input int k, input logic [8:0] er,
                         input logic [8:0] et, input int hold);
    int          lat;
    logic [17:0] exp;
    logic [8:0]  snap;
    exp_q.push_back({er, et});
    check("in_ready_idle", 32'(in_ready), 32'd1);
    din      = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = 12'($urandom_range(0, 4095));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check("latency", 32'(lat), 32'(4 + k));
    exp = exp_q.pop_front();
    check("result_round", 32'({s, e, f, sat}), 32'(exp[17:9]));
    check("trunc_valid", 32'(out_valid_t), 32'd1);
    check("result_trunc", 32'({s_t, e_t, f_t, sat_t}), 32'(exp[8:0]));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    snap = {s, e, f, sat};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      din      = 12'h555;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_stable", 32'({s, e, f, sat}), 32'(snap));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("taken_valid", 32'(out_valid), 32'd0);
    check("taken_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({out_valid, s, e, f, sat}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    //       din      k  round {s,e,f,sat}    trunc {s,e,f,sat}   hold
    run_vec(12'h7FF, 0, {1'b0,3'd7,4'hF,1'b1}, {1'b0,3'd7,4'hF,1'b0}, 0);
    run_vec(12'h07F, 4, {1'b0,3'd4,4'h8,1'b0}, {1'b0,3'd3,4'hF,1'b0}, 0);
    run_vec(12'hFFF, 7, {1'b1,3'd0,4'h1,1'b0}, {1'b1,3'd0,4'h1,1'b0}, 0);
    run_vec(12'h800, 0, {1'b1,3'd7,4'hF,1'b1}, {1'b1,3'd7,4'hF,1'b1}, 0);
    run_vec(12'h000, 7, {1'b0,3'd0,4'h0,1'b0}, {1'b0,3'd0,4'h0,1'b0}, 0);
    run_vec(12'd100, 4, {1'b0,3'd3,4'hD,1'b0}, {1'b0,3'd3,4'hC,1'b0}, 5);
    // Back-to-back: accepted in the IDLE cycle right after the held handshake.
    run_vec(-12'sd1000, 1, {1'b1,3'd7,4'h8,1'b0}, {1'b1,3'd6,4'hF,1'b0}, 0);
    run_vec(12'd1900, 0, {1'b0,3'd7,4'hF,1'b0}, {1'b0,3'd7,4'hE,1'b0}, 0);
    run_vec(12'h400, 0, {1'b0,3'd7,4'h8,1'b0}, {1'b0,3'd7,4'h8,1'b0}, 0);
    run_vec(-12'sd3, 7, {1'b1,3'd0,4'h3,1'b0}, {1'b1,3'd0,4'h3,1'b0}, 0);

    // Reset while normalising 3: in-flight sample is dropped.
    din      = 12'h003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_state_norm", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({out_valid, s, e, f, sat}), 32'd0);
    check("mid_reset_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int rose;
      rose = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (out_valid || out_valid_t) rose = 1;
      end
      check("no_emit_after_reset", 32'(rose), 32'd0);
    end
    run_vec(12'h003, 7, {1'b0,3'd0,4'h3,1'b0}, {1'b0,3'd0,4'h3,1'b0}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_convert_seq.md
Name: fp_convert_seq

Overview:
- Sequential, parametrised successor to the lab-1 combinational floating-point converter.
- Accepts a DIN_W-bit two's-complement sample over a valid/ready handshake and normalises it iteratively, one shift per cycle.
- Emits sign / exponent / significand (value = F × 2^E) with optional round-to-nearest and a saturation flag.
- Sits between the sample source and the compressed-value consumer.

Parameters:
- MAN_W, 4, significand width F.
- EXP_W, 3, exponent width E. Legal only if DIN_W == MAN_W + 2^EXP_W (elaboration-time check, fatal otherwise).
- DIN_W, 12, input width, two's complement.
- ROUND_EN, 1, 1 = round half-up on the first discarded bit; 0 = truncate.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, din is valid.
- in_ready, output, 1, block can accept; high only in IDLE.
- din, input, DIN_W, signed sample.
- out_valid, output, 1, s/e/f/sat valid; held until taken.
- out_ready, input, 1, consumer accepts the result.
- s, output, 1, sign.
- e, output, EXP_W, exponent.
- f, output, MAN_W, significand.
- sat, output, 1, result was clamped to the maximum.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; in_ready = 1.
  - out_valid, s, e, f, sat all 0.
  - Internal mag and cnt cleared.
  - Reset mid-operation discards the in-flight sample; nothing is emitted.
- State machine: IDLE -> ABS -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch s = din[DIN_W-1] and din; go to ABS.
- ABS (1 cycle):
  - mag = |din| as DIN_W-bit unsigned.
  - cnt = 2^EXP_W - 1.
- NORM:
  - If mag[DIN_W-1] = 1 (only din = -2^(DIN_W-1)): set the saturate path and go to ROUND.
  - Else if mag[DIN_W-2] = 1 or cnt = 0: go to ROUND.
  - Else: mag <<= 1, cnt -= 1, stay in NORM.
  - Shift count k is 0 to 2^EXP_W - 1.
- ROUND:
  - ftmp = mag[DIN_W-2 -: MAN_W]; rbit = mag[DIN_W-2-MAN_W].
  - If ROUND_EN and rbit: ftmp += 1.
  - If ftmp overflows to 2^MAN_W: f = 2^(MAN_W-1), e = cnt + 1.
  - If the increment would exceed e max (2^EXP_W - 1), or on the saturate path: e = all ones, f = all ones, sat = 1.
  - Otherwise e = cnt, f = ftmp, sat = 0.
  - Register the outputs and go to DONE.
- DONE:
  - out_valid = 1; outputs stable.
  - On out_ready: out_valid drops next cycle and state returns to IDLE.
  - out_ready while out_valid = 0 is ignored.
- Latency: input accepted at edge T -> out_valid high in cycle T+4+k. Minimum 4, maximum 3 + 2^EXP_W (11 at defaults).
- No new input is accepted from ABS through DONE. A back-to-back accept is possible on the cycle after the DONE handshake.
- Special inputs:
  - din = 0 -> s=0, e=0, f=0.
  - Negative inputs use the magnitude; s = 1.
  - With e = 0, rbit is always 0 (zeros were shifted in), so there is no rounding.
- Outputs change only on the ROUND -> DONE transition and at reset.

Test Plan:
- 12'b0111_1111_1111 (2047), ROUND_EN=1 -> k=0; round overflows e past max, so s=0, e=7, f=1111, sat=1. Out_valid 4 cycles after accept.
- 12'b0000_0111_1111 (127), ROUND_EN=1 -> s=0, e=4, f=1000, sat=0 (round carry renormalises). With ROUND_EN=0 -> e=3, f=1111.
- 12'b1111_1111_1111 (-1) -> s=1, e=0, f=0001, sat=0. Out_valid 11 cycles after accept (k=7).
- 12'b1000_0000_0000 (-2048) -> s=1, e=111, f=1111, sat=1. 12'b0 -> s=0, e=0, f=0.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0, a new in_valid is ignored.
  - Release out_ready: next sample accepted in the IDLE cycle that follows.
- Assert rst_n=0 during NORM on a sample of 12'b0000_0000_0011: all outputs 0 immediately, out_valid never rises, next sample converts normally.
